// File: rtl/des_decrypt_if.sv
// des_decrypt_if: ciphertext/key input handshake and plaintext output handshake of des_decrypt.
interface des_decrypt_if;
  logic        in_valid;
  logic        in_ready;
  logic [64:1] ct;
  logic [64:1] key;
  logic        out_valid;
  logic        out_ready;
  logic [64:1] pt;
  logic        busy;
  modport master (output in_valid, ct, key, out_ready, input in_ready, out_valid, pt, busy);
  modport slave (input in_valid, ct, key, out_ready, output in_ready, out_valid, pt, busy);
endinterface

// File: rtl/des_decrypt.sv
// des_decrypt: iterative DES decryption, one Feistel round per clock, key schedule walked in reverse.
// Data vectors carry FIPS bit 1 in bit 64; the tables below use FIPS bit numbering.
module des_decrypt (
  input  logic         clk,
  input  logic         rst,
  des_decrypt_if.slave s
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  // Each S-box row-major, entry (row*16 + col) is the nibble at that position.
  localparam logic [0:63][3:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [64:1] ip(input logic [64:1] x);
    logic [64:1] y;
    for (int k = 0; k < 64; k++) y[64-k] = x[65-IP_T[k]];
    return y;
  endfunction

  function automatic logic [64:1] fp(input logic [64:1] x);
    logic [64:1] y;
    for (int k = 0; k < 64; k++) y[65-IP_T[k]] = x[64-k];
    return y;
  endfunction

  function automatic logic [56:1] pc1(input logic [64:1] x);
    logic [56:1] y;
    for (int k = 0; k < 56; k++) y[56-k] = x[65-PC1_T[k]];
    return y;
  endfunction

  function automatic logic [48:1] pc2(input logic [56:1] x);
    logic [48:1] y;
    for (int k = 0; k < 48; k++) y[48-k] = x[57-PC2_T[k]];
    return y;
  endfunction

  function automatic logic [32:1] f(input logic [32:1] r, input logic [48:1] kd);
    logic [48:1] x;
    logic [32:1] so;
    logic [32:1] y;
    logic [5:0]  b;
    for (int k = 0; k < 48; k++) x[48-k] = r[32-((4*(k/6)+k%6+31)%32)] ^ kd[48-k];
    for (int k = 0; k < 8; k++) begin
      b = x[48-6*k -: 6];
      so[32-4*k -: 4] = SBOX[k][{b[5], b[0], b[4:1]}];
    end
    for (int k = 0; k < 32; k++) y[32-k] = so[33-P_T[k]];
    return y;
  endfunction

  state_t      r_state, w_next;
  logic [3:0]  r_rnd;
  logic [32:1] r_l, r_r, w_r_new;
  logic [28:1] r_c, r_d, w_c_rot, w_d_rot;
  logic [64:1] r_pt;
  logic        w_accept, w_one;

  assign w_accept = r_state == IDLE && s.in_valid;
  // Right rotation by one when the matching encryption round (16-rnd) is 1, 2, 9 or 16.
  assign w_one = r_rnd == 4'd0 || r_rnd == 4'd7 || r_rnd == 4'd14 || r_rnd == 4'd15;
  assign w_c_rot = w_one ? {r_c[1], r_c[28:2]} : {r_c[2:1], r_c[28:3]};
  assign w_d_rot = w_one ? {r_d[1], r_d[28:2]} : {r_d[2:1], r_d[28:3]};
  assign w_r_new = r_l ^ f(r_r, pc2({r_c, r_d}));
  assign s.pt = r_pt;

  always_comb begin
    w_next = r_state;
    s.in_ready = r_state == IDLE;
    s.out_valid = r_state == DONE;
    s.busy = r_state != IDLE;
    if (w_accept) w_next = ROUND;
    else if (r_state == ROUND && r_rnd == 4'd15) w_next = DONE;
    else if (r_state == DONE && s.out_ready) w_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rnd <= '0;
      r_l <= '0;
      r_r <= '0;
      r_c <= '0;
      r_d <= '0;
      r_pt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        {r_l, r_r} <= ip(s.ct);
        {r_c, r_d} <= pc1(s.key);
        r_rnd <= '0;
      end else if (r_state == ROUND) begin
        r_l <= r_r;
        r_r <= w_r_new;
        r_c <= w_c_rot;
        r_d <= w_d_rot;
        r_rnd <= r_rnd + 4'd1;
        if (r_rnd == 4'd15) r_pt <= fp({w_r_new, r_r});
      end
    end
  end
endmodule

// File: tb/tb_des_decrypt.sv
// tb_des_decrypt: directed and randomized checks of des_decrypt against a FIPS-ordered DES encryption model.
module tb_des_decrypt;
  localparam logic [63:0] K1 = 64'h133457799BBCDFF1, C1 = 64'h85E813540F0AB405, P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73, C2 = 64'h0000000000000000, P2 = 64'h8787878787878787;
  localparam int IP [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                             62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                             57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                             61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                              10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                              14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                              23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int E [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                            12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                            24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                            2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam logic [0:63][3:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  logic clk = 0;
  logic rst = 1;
  int checks = 0, failures = 0, blocks = 0, xfers = 0;

  des_decrypt_if bus ();
  des_decrypt dut (.clk(clk), .rst(rst), .s(bus));

  always #5 clk = ~clk;
  always @(negedge clk) if (bus.out_valid && bus.out_ready) xfers++;

  function automatic logic [1:32] feistel(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] x;
    logic [1:32] so, y;
    logic [1:6]  b;
    for (int i = 1; i <= 48; i++) x[i] = r[E[i-1]] ^ k[i];
    for (int j = 0; j < 8; j++) begin
      b = x[6*j+1 +: 6];
      so[4*j+1 +: 4] = SB[j][int'({b[1], b[6]}) * 16 + int'(b[2:5])];
    end
    for (int i = 1; i <= 32; i++) y[i] = so[P[i-1]];
    return y;
  endfunction

  function automatic logic [1:64] des_enc(input logic [1:64] k, input logic [1:64] m);
    logic [1:28] c, d;
    logic [1:48] sub [1:16];
    logic [1:64] b, o;
    logic [1:32] l, r, t;
    for (int i = 1; i <= 28; i++) begin
      c[i] = k[PC1[i-1]];
      d[i] = k[PC1[i+27]];
    end
    for (int n = 1; n <= 16; n++) begin
      repeat ((n == 1 || n == 2 || n == 9 || n == 16) ? 1 : 2) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
      for (int i = 1; i <= 48; i++) sub[n][i] = PC2[i-1] <= 28 ? c[PC2[i-1]] : d[PC2[i-1]-28];
    end
    for (int i = 1; i <= 64; i++) b[i] = m[IP[i-1]];
    l = b[1:32];
    r = b[33:64];
    for (int n = 1; n <= 16; n++) begin
      t = r;
      r = l ^ feistel(r, sub[n]);
      l = t;
    end
    b = {r, l};
    for (int i = 1; i <= 64; i++) o[IP[i-1]] = b[i];
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; offers one block and returns its plaintext.
  task automatic run(input logic [63:0] k, input logic [63:0] c, output logic [63:0] got);
    int n = 0;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", 64'(bus.in_ready), 64'd1);
    bus.key = k;
    bus.ct = c;
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    check("busy", 64'(bus.busy), 64'd1);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'd16);
    got = bus.pt;
    blocks++;
    if (bus.out_ready) begin
      @(posedge clk); #1;
      check("drain_valid", 64'(bus.out_valid), 64'd0);
      check("drain_ready", 64'(bus.in_ready), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] got, got2, k, m, c;
    bus.in_valid = 0;
    bus.out_ready = 1;
    bus.ct = '0;
    bus.key = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_pt", bus.pt, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    check("idle_ready", 64'(bus.in_ready), 64'd1);
    check("model_enc", des_enc(K1, P1), C1);

    run(K1, C1, got);
    check("vec1", got, P1);
    run(K2, C2, got);
    check("vec2", got, P2);

    bus.out_ready = 0;
    run(K1, C1, got);
    check("bp_pt", got, P1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.ct = {$urandom, $urandom};
      @(posedge clk); #1;
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold", bus.pt, P1);
      check("bp_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    @(posedge clk); #1;
    check("bp_drain", 64'(bus.out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_idle", 64'(bus.busy), 64'd0);

    bus.key = K2;
    bus.ct = C2;
    bus.in_valid = 1;
    @(posedge clk); #1;
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy", 64'(bus.busy), 64'd1);
    rst = 1;
    #1;
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_pt", bus.pt, 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk);
    bus.in_valid = 0;
    @(negedge clk) rst = 0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_quiet", 64'(bus.out_valid), 64'd0);
    run(K1, C1, got);
    check("post_rst", got, P1);

    run(K1, C1, got);
    run(K2, C2, got2);
    check("b2b_first", got, P1);
    check("b2b_second", got2, P2);

    for (int i = 0; i < 500; i++) begin
      k = {$urandom, $urandom};
      m = {$urandom, $urandom};
      c = des_enc(k, m);
      run(k, c, got);
      check("roundtrip", got, m);
      run(k ^ ({$urandom, $urandom} & 64'h0101010101010101), c, got);
      check("parity", got, m);
    end

    @(posedge clk); #1;
    check("xfers", 64'(xfers), 64'(blocks));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
